dma_priority_resolver: RTL and testbench

- Upstream request stage of the 8237A-compatible DMA controller.
- Synchronizes the four DREQ inputs and merges them with software requests, the mask register and the command-register enable, polarity and priority controls.
- Picks one winning channel and holds it as one-hot `VALID_DREQ[3:0]` for the timing-control FSM until that FSM reports end of service.
- Drives the DACK pins from the timing FSM's `validDACK` strobe.

---
 rtl/dma_pkg.sv | 12 +
 rtl/dma_prio_arbiter.sv | 16 +
 rtl/dma_priority_resolver.sv | 85 ++++++++
 tb/tb_dma_priority_resolver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA request stage
package dma_pkg;
  localparam int NCH = 4;
  localparam int CMD_DISABLE = 2;
  localparam int CMD_ROTATE = 4;
  localparam int CMD_DREQ_LOW = 6;
  localparam int CMD_DACK_HIGH = 7;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  function automatic logic [1:0] oneHotIdx(input logic [NCH-1:0] v);
    return {v[3] | v[2], v[3] | v[1]};
  endfunction
endpackage

// File: rtl/dma_prio_arbiter.sv
// dma_prio_arbiter: one-hot winner of eff, search starting at channel rp and wrapping 3->0
module dma_prio_arbiter
  import dma_pkg::*;
(
  input  logic [NCH-1:0] eff,
  input  logic [1:0]     rp,
  output logic [NCH-1:0] win
);
  logic [NCH-1:0] rot, pick;
  // Rotate so channel rp sits at bit 0, keep the lowest set bit, rotate back
  always_comb begin
    rot = NCH'({eff, eff} >> rp);
    pick = rot & -rot;
    win = NCH'(({pick, pick} << rp) >> NCH);
  end
endmodule

// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver: DREQ sync, request merge, grant FSM and DACK drive; rotating priority built only with DMA_ROTATING_PRIORITY_EN
module dma_priority_resolver #(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           CS_N,
  input  logic           HLDA,
  input  logic [NCH-1:0] DREQ,
  input  logic [7:0]     commandReg,
  input  logic [NCH-1:0] maskReg,
  input  logic [NCH-1:0] requestReg,
  input  logic           validDACK,
  input  logic           svcDone,
  output logic [NCH-1:0] VALID_DREQ,
  output logic [NCH-1:0] DACK,
  output logic [1:0]     activeCh,
  output logic           reqPending,
  output logic [NCH-1:0] clrSwReq
);
  import dma_pkg::*;
  state_t state, stateNext;
  logic [NCH-1:0] dreqS, eff, win, grant, grantNext, dackAct, clrNext;
  logic [1:0] arbRp;
  logic programming;
  logic unusedBits;
  assign eff = (dreqS | requestReg) & ~maskReg & {NCH{~commandReg[CMD_DISABLE]}};
  assign programming = !CS_N && !HLDA;
  assign VALID_DREQ = grant;
  assign reqPending = |grant;
  assign activeCh = oneHotIdx(grant);
  assign DACK = dackAct ^ {NCH{~commandReg[CMD_DACK_HIGH]}};
  dma_prio_arbiter uArb (
    .eff(eff),
    .rp(arbRp),
    .win(win)
  );
  // Sync stage, FSM state, grant, DACK and software-clear registers
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      grant <= '0;
      dreqS <= '0;
      dackAct <= '0;
      clrSwReq <= '0;
    end else begin
      state <= stateNext;
      grant <= grantNext;
      dreqS <= DREQ ^ {NCH{commandReg[CMD_DREQ_LOW]}};
      dackAct <= grant & {NCH{validDACK}};
      clrSwReq <= clrNext;
    end
  // Arbitrate from IDLE, hold the grant until svcDone, then one dead RELEASE cycle
  always_comb begin
    stateNext = state;
    grantNext = grant;
    clrNext = '0;
    case (state)
      IDLE:
        if (|eff && !programming) begin
          stateNext = GRANT;
          grantNext = win;
        end
      GRANT:
        if (svcDone) begin
          stateNext = RELEASE;
          grantNext = '0;
          clrNext = grant & requestReg;
        end
      default: stateNext = IDLE;
    endcase
  end
`ifdef DMA_ROTATING_PRIORITY_EN
  logic [1:0] rp;
  // Rotation pointer moves just past the channel whose service ended
  always_ff @(posedge CLK)
    if (RESET) rp <= 2'd0;
    else if (state == GRANT && svcDone && commandReg[CMD_ROTATE]) rp <= activeCh + 2'd1;
  assign arbRp = commandReg[CMD_ROTATE] ? rp : 2'd0;
  assign unusedBits = ^{commandReg[5], commandReg[3], commandReg[1:0]};
`else
  assign arbRp = 2'd0;
  assign unusedBits = ^{commandReg[5:3], commandReg[1:0]};
`endif
endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb_dma_priority_resolver: directed and random checks against a behavioural model of the request stage
module tb_dma_priority_resolver;
  logic CLK = 1'b0;
  logic RESET, CS_N, HLDA, validDACK, svcDone;
  logic [3:0] DREQ, maskReg, requestReg, VALID_DREQ, DACK, clrSwReq;
  logic [7:0] commandReg;
  logic [1:0] activeCh;
  logic reqPending;
  int nCompared = 0;
  int nMismatched = 0;
  int mGrant = -1;
  int mPhase = 0;
  int mRp = 0;
  logic [3:0] mDreqS = 4'h0;
  logic [3:0] mDack = 4'h0;
  logic [3:0] mClr = 4'h0;
  bit mValid = 0;

  always #5 CLK = ~CLK;

  dma_priority_resolver #(.NCH(4)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .CS_N(CS_N),
    .HLDA(HLDA),
    .DREQ(DREQ),
    .commandReg(commandReg),
    .maskReg(maskReg),
    .requestReg(requestReg),
    .validDACK(validDACK),
    .svcDone(svcDone),
    .VALID_DREQ(VALID_DREQ),
    .DACK(DACK),
    .activeCh(activeCh),
    .reqPending(reqPending),
    .clrSwReq(clrSwReq)
  );

  function automatic bit rotating();
`ifdef DMA_ROTATING_PRIORITY_EN
    return commandReg[4];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: one call per rising edge, using the inputs held across that edge
  task automatic modelEdge();
    logic [3:0] eff;
    int start;
    eff = (mDreqS | requestReg) & ~maskReg & (commandReg[2] ? 4'h0 : 4'hF);
    if (RESET) begin
      mGrant = -1;
      mPhase = 0;
      mRp = 0;
      mDreqS = 4'h0;
      mDack = 4'h0;
      mClr = 4'h0;
      mValid = 1;
    end else begin
      mDack = (mGrant >= 0 && validDACK) ? 4'(1 << mGrant) : 4'h0;
      mClr = 4'h0;
      if (mPhase == 0) begin
        if (eff != 4'h0 && (CS_N || HLDA)) begin
          start = rotating() ? mRp : 0;
          for (int k = 0; k < 4; k++)
            if (mGrant < 0 && eff[(start + k) % 4]) mGrant = (start + k) % 4;
          mPhase = 1;
        end
      end else if (mPhase == 1) begin
        if (svcDone) begin
          if (requestReg[mGrant]) mClr = 4'(1 << mGrant);
          if (rotating()) mRp = (mGrant + 1) % 4;
          mGrant = -1;
          mPhase = 2;
        end
      end else mPhase = 0;
      mDreqS = DREQ ^ {4{commandReg[6]}};
    end
  endtask

  task automatic checkAll(input string tag);
    logic [3:0] expVd;
    expVd = (mGrant >= 0) ? 4'(1 << mGrant) : 4'h0;
    check({tag, "/vd"}, 8'(VALID_DREQ), 8'(expVd));
    check({tag, "/pend"}, 8'(reqPending), 8'(expVd != 4'h0));
    check({tag, "/clr"}, 8'(clrSwReq), 8'(mClr));
    check({tag, "/dack"}, 8'(DACK), 8'(mDack ^ (commandReg[7] ? 4'h0 : 4'hF)));
    if (mGrant >= 0) check({tag, "/ch"}, 8'(activeCh), 8'(mGrant));
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
    if (mValid) checkAll(tag);
  endtask

  task automatic doReset();
    RESET = 1'b1;
    tick("rst");
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; CS_N = 1'b1; HLDA = 1'b0; validDACK = 1'b0; svcDone = 1'b0;
    DREQ = 4'h0; maskReg = 4'h0; requestReg = 4'h0; commandReg = 8'h80;
    tick("rst0");
    check("rst_vd", 8'(VALID_DREQ), 8'h00);
    check("rst_dack", 8'(DACK), 8'h00);
    check("rst_ch", 8'(activeCh), 8'h00);
    check("rst_clr", 8'(clrSwReq), 8'h00);
    RESET = 1'b0;
    commandReg = 8'h00;
    // fixed priority
    DREQ = 4'b1010;
    tick("fix1");
    check("fix_early", 8'(VALID_DREQ), 8'h00);
    tick("fix2");
    check("fix_vd", 8'(VALID_DREQ), 8'h02);
    check("fix_ch", 8'(activeCh), 8'h01);
`ifdef DMA_ROTATING_PRIORITY_EN
    // rotating priority
    doReset();
    commandReg = 8'h10;
    DREQ = 4'b1010;
    tick("rot1"); tick("rot2");
    check("rot_first", 8'(VALID_DREQ), 8'h02);
    DREQ = 4'b1011; svcDone = 1'b1;
    tick("rot3");
    svcDone = 1'b0;
    tick("rot4"); tick("rot5");
    check("rot_ch3", 8'(VALID_DREQ), 8'h08);
    svcDone = 1'b1;
    tick("rot6");
    svcDone = 1'b0;
    tick("rot7"); tick("rot8");
    check("rot_wrap", 8'(VALID_DREQ), 8'h01);
    svcDone = 1'b1;
    tick("rot9");
    svcDone = 1'b0;
    DREQ = 4'b1111;
    doReset();
    tick("rot10"); tick("rot11");
    check("rot_rst_rp", 8'(VALID_DREQ), 8'h01);
    commandReg = 8'h00;
`endif
    // mask and disable
    doReset();
    maskReg = 4'b0001; DREQ = 4'b0001;
    tick("msk1"); tick("msk2"); tick("msk3");
    check("msk_none", 8'(VALID_DREQ), 8'h00);
    commandReg = 8'h04; requestReg = 4'b0100;
    tick("dis1"); tick("dis2");
    check("dis_none", 8'(VALID_DREQ), 8'h00);
    commandReg = 8'h00;
    tick("dis3");
    check("dis_clr_vd", 8'(VALID_DREQ), 8'h04);
    svcDone = 1'b1;
    tick("sw1");
    check("sw_clr", 8'(clrSwReq), 8'h04);
    svcDone = 1'b0; requestReg = 4'h0; maskReg = 4'h0; DREQ = 4'h0;
    tick("sw2");
    // polarity
    doReset();
    commandReg = 8'hC0; DREQ = 4'b1101;
    tick("pol1"); tick("pol2");
    check("pol_vd", 8'(VALID_DREQ), 8'h02);
    validDACK = 1'b1;
    tick("pol3");
    check("pol_dack_on", 8'(DACK), 8'h02);
    validDACK = 1'b0;
    tick("pol4");
    check("pol_dack_off", 8'(DACK), 8'h00);
    commandReg = 8'h00;
    tick("pol5");
    check("pol_idle_low", 8'(DACK), 8'h0F);
    validDACK = 1'b1;
    tick("pol6");
    check("pol_act_low", 8'(DACK), 8'h0D);
    validDACK = 1'b0;
    // reset mid-service
    doReset();
    DREQ = 4'b0100;
    tick("mid1"); tick("mid2");
    check("mid_vd", 8'(VALID_DREQ), 8'h04);
    validDACK = 1'b1;
    tick("mid3");
    check("mid_dack", 8'(DACK), 8'h0B);
    RESET = 1'b1;
    tick("mid4");
    check("mid_rst_vd", 8'(VALID_DREQ), 8'h00);
    check("mid_rst_dack", 8'(DACK), 8'h0F);
    RESET = 1'b0; validDACK = 1'b0; DREQ = 4'h0;
    // programming block and simultaneous events
    doReset();
    DREQ = 4'b0001; CS_N = 1'b0; HLDA = 1'b0;
    tick("prg1"); tick("prg2"); tick("prg3");
    check("prg_block", 8'(VALID_DREQ), 8'h00);
    CS_N = 1'b1;
    tick("prg4"); tick("prg5");
    check("prg_grant", 8'(VALID_DREQ), 8'h01);
    DREQ = 4'b0011; svcDone = 1'b1;
    tick("sim1");
    check("sim_rel", 8'(VALID_DREQ), 8'h00);
    svcDone = 1'b0;
    tick("sim2");
    check("sim_idle", 8'(VALID_DREQ), 8'h00);
    tick("sim3");
    check("sim_regrant", 8'(VALID_DREQ), 8'h01);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      RESET = ($urandom % 50) == 0;
      CS_N = ($urandom % 4) != 0;
      HLDA = $urandom % 2;
      DREQ = 4'($urandom);
      maskReg = (($urandom % 2) == 0) ? 4'h0 : 4'($urandom);
      requestReg = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
      commandReg = 8'($urandom) & (($urandom % 4) == 0 ? 8'hFF : 8'hFB);
      validDACK = $urandom % 2;
      svcDone = ($urandom % 4) == 0;
      tick("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
